dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single-port data memory (dmem) between the core
//  load/store path (port 0) and a memory loader/DMA engine (port 1). Round-robin grant,
//  one access per cycle, single-cycle-latency synchronous read data with per-port return
//  tagging. Sits between riscvsingle/top and dmem; a denied core request stalls the PC.
// PARAMETERS
//  AW        32  address width (word aligned; bits [1:0] ignored by memory)
//  DW        32  data width
//  MAX_WAIT  4   cycles a requesting port may be denied before forced grant (1..15)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  reset        in   1   asynchronous, active-low reset
//  req0         in   1   core request (held until gnt0)
//  we0          in   1   core write enable (1=store, 0=load)
//  addr0        in   AW  core address
//  wdata0       in   DW  core store data
//  gnt0         out  1   core request accepted this cycle (combinational)
//  rvalid0      out  1   core load data valid (cycle after load grant)
//  rdata0       out  DW  core load data
//  req1,we1,addr1,wdata1,gnt1,rvalid1,rdata1  --  same as port 0, for loader/DMA
//  mem_we       out  1   memory write strobe
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data, valid cycle after address (sync read)
//  stall        out  1   req0 & ~gnt0; core holds PC and instruction
// BEHAVIOUR
//  - Reset (reset=0): gnt*, rvalid*, mem_we, stall = 0; rdata*, mem_addr, mem_wdata = 0;
//    last_gnt=1 (port 0 wins first tie); wait counters = 0; pending-read tag cleared.
//  - Arbitration (comb.): one req -> that port granted. Both req -> port != last_gnt,
//    unless a port's wait counter == MAX_WAIT, which forces that port. Neither -> idle.
//  - Granted port drives mem_we/mem_addr/mem_wdata same cycle; idle: mem_we=0, addr/wdata held.
//  - last_gnt updates on every grant; wait counter of a requesting-but-denied port +1,
//    saturating at MAX_WAIT; cleared on that port's grant or when its req drops.
//  - Read return: granted load registers tag {valid,port}; next cycle rvalidN=1 and
//    rdataN=mem_rdata for tagged port only; other port's rvalid=0, rdata holds.
//  - Back-to-back: new grant allowed in the rvalid cycle (fully pipelined, 1 access/cycle).
//  - Stores: no rvalid; write commits at edge ending the grant cycle. Load to same address
//    granted next cycle returns new data.
//  - Same-cycle req from both ports to same address: arbitration order defines ordering;
//    no merging.
//  - Reset mid-read: pending tag dropped, no rvalid ever issued for that load.
//  - req deasserted without grant: request withdrawn, no side effects.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_stall (32 b each,
//    reset 0, wrap at 2^32): grants per port and cycles with stall=1; stat_clr (in, 1)
//    synchronously zeroes all three, taking priority over same-cycle increments.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset low 3 cycles, reqs high -> all outputs 0; release -> first tie grants port 0.
//  2 Both req loads every cycle, MAX_WAIT=4 -> grants alternate 0,1,0,1; rvalid follows 1 cycle.
//  3 Port1 store 0x64<-25, next cycle port0 load 0x64 -> rvalid0=1, rdata0=25, rvalid1=0.
//  4 Port0 only for 10 cycles -> gnt0 every cycle, stall=0; add req1 -> stall=1 alternate cycles.
//  5 Assert reset during load grant cycle -> no rvalid after release; counters/tag cleared.
//  6 DMEM_ARB_STATS_EN: 5 grants port0, 3 port1, 3 stall cycles -> stat_gnt0=5,
//    stat_gnt1=3, stat_stall=3; stat_clr with grant same cycle -> all read 0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port, synchronous-read data memory between the core
//   load/store path (port 0) and a loader/DMA engine (port 1). Round-robin
//   arbitration with a starvation guard (MAX_WAIT), one access per cycle, and
//   per-port tagged read return one cycle after a load grant.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   reqN/weN/addrN/wdataN requester N access (held until gntN)
//   gntN                  combinational grant for this cycle
//   rvalidN/rdataN        load return, cycle after the load grant
//   mem_we/addr/wdata     memory command (address/data held while idle)
//   mem_rdata             memory read data, valid cycle after address
//   stall                 core request denied this cycle
//
// Optional build feature (macro DMEM_ARB_STATS_EN)
//   Adds stat_clr input and stat_gnt0/stat_gnt1/stat_stall 32-bit counters.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    input  logic          stat_clr,
    output logic [31:0]   stat_gnt0,
    output logic [31:0]   stat_gnt1,
    output logic [31:0]   stat_stall,
`endif
    output logic          stall
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic          last_gnt_q, last_gnt_d;
    logic [3:0]    wait0_q, wait0_d, wait1_q, wait1_d;
    logic          tag_valid_q, tag_valid_d;
    logic          tag_port_q, tag_port_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Saturating denial counter; any grant or withdrawn request restarts it.
    function automatic logic [3:0] next_wait(input logic req, input logic gnt,
                                             input logic [3:0] cur);
        if (!req || gnt) begin
            return 4'd0;
        end else if (cur == MAX_W) begin
            return cur;
        end else begin
            return cur + 4'd1;
        end
    endfunction

    // Grant selection: starved port first, otherwise the port not served last.
    // Grants are masked while reset is held so nothing reaches the memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            if (req0 && req1) begin
                if (wait0_q == MAX_W) begin
                    gnt0 = 1'b1;
                end else if (wait1_q == MAX_W) begin
                    gnt1 = 1'b1;
                end else if (last_gnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b0;
            end
        end else begin
            gnt0 = 1'b0;
        end
    end

    // Memory command mux; address and data hold their last value when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Read return: the tag routes mem_rdata to one port; the other port holds.
    always_comb begin
        rvalid0 = tag_valid_q & ~tag_port_q;
        rvalid1 = tag_valid_q &  tag_port_q;
        if (rvalid0) begin
            rdata0 = mem_rdata;
        end else begin
            rdata0 = rdata0_q;
        end
        if (rvalid1) begin
            rdata1 = mem_rdata;
        end else begin
            rdata1 = rdata1_q;
        end
        stall = req0 & ~gnt0 & reset;
    end

    // Next-state computation for arbitration history, tag and held buses.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        if (gnt0 || gnt1) begin
            last_gnt_d = gnt1;
        end else begin
            last_gnt_d = last_gnt_q;
        end
        wait0_d     = next_wait(req0, gnt0, wait0_q);
        wait1_d     = next_wait(req1, gnt1, wait1_q);
        tag_valid_d = (gnt0 & ~we0) | (gnt1 & ~we1);
        tag_port_d  = gnt1;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt_q  <= 1'b1;
            wait0_q     <= 4'd0;
            wait1_q     <= 4'd0;
            tag_valid_q <= 1'b0;
            tag_port_q  <= 1'b0;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            rdata0_q    <= {DW{1'b0}};
            rdata1_q    <= {DW{1'b0}};
        end else begin
            last_gnt_q  <= last_gnt_d;
            wait0_q     <= wait0_d;
            wait1_q     <= wait1_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0_q, stat_gnt0_d;
    logic [31:0] stat_gnt1_q, stat_gnt1_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Event counters; clear wins over a same-cycle increment, wrap naturally.
    always_comb begin
        stat_gnt0_d  = stat_gnt0_q;
        stat_gnt1_d  = stat_gnt1_q;
        stat_stall_d = stat_stall_q;
        if (stat_clr) begin
            stat_gnt0_d  = 32'd0;
            stat_gnt1_d  = 32'd0;
            stat_stall_d = 32'd0;
        end else begin
            stat_gnt0_d  = stat_gnt0_q  + {31'd0, gnt0};
            stat_gnt1_d  = stat_gnt1_q  + {31'd0, gnt1};
            stat_stall_d = stat_stall_q + {31'd0, stall};
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_gnt0_q  <= 32'd0;
            stat_gnt1_q  <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_gnt0_q  <= stat_gnt0_d;
            stat_gnt1_q  <= stat_gnt1_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_gnt0  = stat_gnt0_q;
    assign stat_gnt1  = stat_gnt1_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
